audio_adc_capture: RTL and testbench
====================================

// Module: audio_adc_capture
// PURPOSE
//   Receive-side I2S deserializer for the audio codec ADC path. Oversamples AUD_BCLK, AUD_ADCLRCK and
//   AUD_ADCDAT in the 100 MHz CLK domain and assembles {left,right} sample frames. Buffers frames in a
//   small FIFO for the RAM write path (record mode), the counterpart of the RAM-to-DACDAT playback path.
// PARAMETERS
//   SAMPLE_WIDTH  16  bits per channel word, captured MSB first
//   FIFO_DEPTH    8   frame FIFO entries; power of two, >= 2
//   SYNC_STAGES   2   synchronizer flops on each codec input, >= 2
// PORTS
//   CLK           in   1               100 MHz system clock; the only clock
//   reset         in   1               asynchronous, active-low
//   enable        in   1               1 = capture, 0 = idle (record switch/PicoBlaze control)
//   adc_bclk      in   1               codec bit clock (AUD_BCLK), asynchronous to CLK
//   adc_lrck      in   1               codec ADC LR clock (AUD_ADCLRCK); 0 = left, 1 = right
//   adc_dat       in   1               codec ADC serial data (AUD_ADCDAT)
//   sample_data   out  2*SAMPLE_WIDTH  FIFO head {left,right}; valid only while sample_valid=1
//   sample_valid  out  1               FIFO not empty (first-word-fall-through)
//   sample_ready  in   1               consumer pop; pop occurs when sample_valid & sample_ready
//   fifo_level    out  $clog2(FIFO_DEPTH)+1  current frame count, 0..FIFO_DEPTH
//   overflow      out  1               sticky: frame dropped because FIFO was full
//   frame_error   out  1               sticky: LRCK toggled before SAMPLE_WIDTH bits were captured
//   clear_flags   in   1               1-cycle pulse clears overflow and frame_error
// BEHAVIOUR
//   Reset (reset=0, asynchronous): all outputs 0, FIFO empty, FSM in IDLE, synchronizers cleared.
//   Input sampling: each of bclk, lrck and dat passes through SYNC_STAGES flops with equal delay. A bit
//     event is a 0->1 transition of synced bclk. On each bit event, synced lrck and dat are sampled.
//   I2S framing (one-bit delay): the bit event at which sampled lrck differs from the previous sampled
//     lrck is the delay bit and is discarded. The next SAMPLE_WIDTH bit events carry the word, MSB first.
//     Any further bits before the next lrck change are ignored.
//   FSM (bit-event driven, except IDLE and abort exits):
//     IDLE  -> SYNC when enable=1.
//     SYNC  : waits for an lrck 1->0 change (left-word delay bit) -> SHIFT_L; never starts mid-frame.
//     SHIFT_L: shifts SAMPLE_WIDTH bits into left_reg -> PAD_L.
//     PAD_L : ignores bits until lrck 0->1 change -> SHIFT_R.
//     SHIFT_R: shifts SAMPLE_WIDTH bits into right_reg; on the last bit, issues a push -> PAD_R.
//     PAD_R : ignores bits until lrck 1->0 change -> SHIFT_L.
//   Short word: an lrck change during SHIFT_L/SHIFT_R before the bit count reaches SAMPLE_WIDTH sets
//     frame_error, discards the partial frame with no push, and transitions as if that change had been
//     seen in PAD (1->0 -> SHIFT_L, 0->1 -> SYNC).
//   Latency: sample_valid rises no later than SYNC_STAGES+3 CLK cycles after the adc_bclk rising edge
//     carrying the right-channel LSB, when the FIFO was empty.
//   enable=0 in any state: next cycle FSM=IDLE; partial frame discarded. FIFO contents, the flags and
//     the pop path remain operational.
//   FIFO: push accepted if level<FIFO_DEPTH, or if level=FIFO_DEPTH with a pop in the same cycle.
//     Otherwise the frame is dropped and overflow is set; FIFO contents are unchanged.
//   Simultaneous push+pop: level is unchanged. Pointers wrap modulo FIFO_DEPTH.
//   Pop with sample_valid=0 is ignored.
//   Flag priority: a set event in the same cycle as clear_flags wins (flag stays 1).
//   Widths: bit counter is $clog2(SAMPLE_WIDTH+1) bits and saturates at SAMPLE_WIDTH in PAD states.
// STRUCTURE
//   audio_defs.vh (shared with the playback serializer): SAMPLE_WIDTH default, LRCK_LEFT=0, FSM state
//     encodings (3-bit localparams).
//   Sub-module sync_frame_fifo (WIDTH=2*SAMPLE_WIDTH, DEPTH=FIFO_DEPTH): FWFT, level, full/empty.
//   The FSM, synchronizers and shift registers stay in this module.
// TESTING (codec BFM: BCLK 3.072 MHz, 32 bits per LRCK half, data driven on BCLK falling edge)
//   1. Reset, enable=1, send L=16'hA5C3 R=16'h5A3C, sample_ready=1 -> one pop with sample_data=32'hA5C35A3C.
//   2. Enable asserted mid-right-word -> first frame output is the next complete L/R pair; no garbage.
//   3. sample_ready=0, send 9 frames -> fifo_level=8, overflow=1; pop returns frames 1..8 in order.
//   4. BFM ends left word after 10 bits -> frame_error=1, no push; the following frame is captured correctly.
//   5. enable=0 during SHIFT_R with 3 frames queued -> no push; fifo_level stays 3; all 3 pop intact.
//   6. reset pulsed low mid-frame -> all outputs 0 within 1 cycle; capture resumes correctly after SYNC.

Source files
------------

// File: rtl/audio_adc_capture_pkg.sv
// Shared definitions for the codec ADC capture path: channel polarity, FSM encoding
// and the bundled codec pin type carried through the synchronizers.
package audio_adc_capture_pkg;

  localparam int   SAMPLE_WIDTH_DEF = 16;
  localparam logic LRCK_LEFT        = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_SHIFT_L = 3'd2,
    ST_PAD_L   = 3'd3,
    ST_SHIFT_R = 3'd4,
    ST_PAD_R   = 3'd5
  } cap_state_e;

  typedef struct packed {
    logic bclk;
    logic lrck;
    logic dat;
  } codec_pins_t;

endpackage

// File: rtl/sync_frame_fifo.sv
// First-word-fall-through frame FIFO with level count; DEPTH must be a power of two
// so the pointers wrap naturally.
module sync_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a frame when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/audio_adc_capture.sv
// I2S receive deserializer: oversamples the codec ADC pins in the CLK domain, frames
// {left,right} words and queues them in a FWFT FIFO for the record path.
module audio_adc_capture
  import audio_adc_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int FIFO_DEPTH   = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          adc_bclk,
  input  logic                          adc_lrck,
  input  logic                          adc_dat,
  output logic [2*SAMPLE_WIDTH-1:0]     sample_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_error,
  input  logic                          clear_flags
);

  localparam int             CW       = $clog2(SAMPLE_WIDTH+1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(SAMPLE_WIDTH-1);

  codec_pins_t [SYNC_STAGES-1:0] sync_q;
  codec_pins_t                   pins_s;
  logic                          bclk_d, lrck_d;
  logic                          bit_ev, lr_chg, lr_left;

  cap_state_e                    state, state_nxt;
  logic [CW-1:0]                 bcnt;
  logic [SAMPLE_WIDTH-1:0]       left_reg, right_reg;
  logic                          shift_l, shift_r, cnt_clr, push, err_set;
  logic                          push_q, ovf_set;
  logic                          fifo_full, fifo_empty;

  // All three pins share one chain so bclk, lrck and dat stay cycle-aligned.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], adc_bclk, adc_lrck, adc_dat};
  end

  assign pins_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      bclk_d <= 1'b0;
      lrck_d <= 1'b0;
    end else begin
      bclk_d <= pins_s.bclk;
      if (bit_ev) lrck_d <= pins_s.lrck;
    end
  end

  assign bit_ev  = pins_s.bclk & ~bclk_d;
  assign lr_chg  = bit_ev & (pins_s.lrck ^ lrck_d);
  assign lr_left = (pins_s.lrck == LRCK_LEFT);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) state_nxt = ST_IDLE;
    else begin
      case (state)
        ST_IDLE:  state_nxt = ST_SYNC;
        ST_SYNC:  if (lr_chg && lr_left) state_nxt = ST_SHIFT_L;
        ST_SHIFT_L, ST_SHIFT_R: begin
          // A short word restarts framing from whichever channel edge cut it off.
          if (lr_chg)
            state_nxt = lr_left ? ST_SHIFT_L : ST_SYNC;
          else if (bit_ev && bcnt == LAST_BIT)
            state_nxt = (state == ST_SHIFT_L) ? ST_PAD_L : ST_PAD_R;
        end
        ST_PAD_L: if (lr_chg && !lr_left) state_nxt = ST_SHIFT_R;
        ST_PAD_R: if (lr_chg && lr_left)  state_nxt = ST_SHIFT_L;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    shift_l = 1'b0;
    shift_r = 1'b0;
    cnt_clr = 1'b0;
    push    = 1'b0;
    err_set = 1'b0;
    if (enable) begin
      case (state)
        ST_SYNC, ST_PAD_L, ST_PAD_R: cnt_clr = lr_chg;
        ST_SHIFT_L, ST_SHIFT_R: begin
          if (lr_chg) begin
            err_set = 1'b1;
            cnt_clr = 1'b1;
          end else if (bit_ev) begin
            shift_l = (state == ST_SHIFT_L);
            shift_r = (state == ST_SHIFT_R);
            push    = (state == ST_SHIFT_R) && (bcnt == LAST_BIT);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      bcnt      <= '0;
      left_reg  <= '0;
      right_reg <= '0;
      push_q    <= 1'b0;
    end else begin
      if (!enable || cnt_clr)    bcnt <= '0;
      else if (shift_l | shift_r) bcnt <= bcnt + 1'b1;
      if (shift_l) left_reg  <= {left_reg[SAMPLE_WIDTH-2:0], pins_s.dat};
      if (shift_r) right_reg <= {right_reg[SAMPLE_WIDTH-2:0], pins_s.dat};
      // Push one cycle after the last shift so the frame registers are complete.
      push_q <= push;
    end
  end

  assign ovf_set = push_q & fifo_full & ~(sample_ready & ~fifo_empty);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (ovf_set)          overflow    <= 1'b1;
      else if (clear_flags) overflow    <= 1'b0;
      if (err_set)          frame_error <= 1'b1;
      else if (clear_flags) frame_error <= 1'b0;
    end
  end

  sync_frame_fifo #(
    .WIDTH (2*SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .reset     (reset),
    .push      (push_q),
    .push_data ({left_reg, right_reg}),
    .pop       (sample_ready),
    .head      (sample_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign sample_valid = ~fifo_empty;

endmodule

// File: tb/tb_audio_adc_capture.sv
// Directed bench: an I2S codec BFM drives frames while a queue model of expected
// frames is checked against the FIFO head on every cycle it is valid.
module tb_audio_adc_capture;

  localparam int SW = 16;
  localparam int FD = 8;
  localparam int SS = 2;
  localparam int HB = 163;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        adc_bclk = 1'b1;
  logic        adc_lrck = 1'b1;
  logic        adc_dat = 1'b0;
  logic        sample_ready = 1'b0;
  logic        clear_flags = 1'b0;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic [3:0]  fifo_level;
  logic        overflow, frame_error;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_pop = '0;

  always #5 CLK = ~CLK;

  audio_adc_capture #(.SAMPLE_WIDTH(SW), .FIFO_DEPTH(FD), .SYNC_STAGES(SS)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .enable       (enable),
    .adc_bclk     (adc_bclk),
    .adc_lrck     (adc_lrck),
    .adc_dat      (adc_dat),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .frame_error  (frame_error),
    .clear_flags  (clear_flags)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FWFT head must always equal the oldest expected frame; a pop retires it.
  always @(negedge CLK) begin
    if (reset && sample_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: got %h with no frame expected", sample_data);
      end else begin
        if (sample_data !== exp_q[0]) begin
          n_err++;
          $display("FAIL head_data: got %h expected %h", sample_data, exp_q[0]);
        end
        if (sample_ready) begin
          last_pop = sample_data;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic model_push(input logic [31:0] f);
    if (exp_q.size() < FD) exp_q.push_back(f);
  endtask

  task automatic do_hook(input int act);
    @(posedge CLK);
    #1;
    case (act)
      1: enable = 1'b1;
      2: enable = 1'b0;
      3: begin
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("rst_valid", 64'(sample_valid), 64'(0));
        check("rst_data",  64'(sample_data),  64'(0));
        check("rst_level", 64'(fifo_level),   64'(0));
        check("rst_flags", 64'({overflow, frame_error}), 64'(0));
        #20;
        reset = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic lat_check();
    bit seen = 1'b0;
    for (int i = 0; i < SS + 3 && !seen; i++) begin
      @(posedge CLK);
      #1;
      if (sample_valid) seen = 1'b1;
    end
    check("latency", 64'(seen), 64'(1));
  endtask

  task automatic bit_slot(input logic lr, input logic d, input int act,
                          input bit do_push, input logic [31:0] frm, input bit lat);
    adc_bclk = 1'b0;
    adc_lrck = lr;
    adc_dat  = d;
    fork
      begin #HB; end
      begin if (act != 0) do_hook(act); end
    join
    adc_bclk = 1'b1;
    if (do_push) model_push(frm);
    fork
      begin #HB; end
      begin if (lat) lat_check(); end
    join
  endtask

  // Slot 0 of each half is the I2S delay bit; slots 1..16 carry the word MSB first.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit exp,
                            input int lslots = 32, input int hk_half = -1,
                            input int hk_slot = 0, input int hk_act = 0, input bit lat = 0);
    for (int s = 0; s < lslots; s++)
      bit_slot(1'b0, (s >= 1 && s <= 16) ? l[16-s] : 1'($urandom),
               (hk_half == 0 && s == hk_slot) ? hk_act : 0, 1'b0, 32'h0, 1'b0);
    for (int s = 0; s < 32; s++)
      bit_slot(1'b1, (s >= 1 && s <= 16) ? r[16-s] : 1'($urandom),
               (hk_half == 1 && s == hk_slot) ? hk_act : 0,
               exp && (s == 16), {l, r}, lat && (s == 16));
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    idle(1);
    clear_flags = 1'b0;
    idle(1);
  endtask

  initial begin
    #2 reset = 1'b0;
    #20;
    check("reset_valid", 64'(sample_valid), 64'(0));
    check("reset_data",  64'(sample_data),  64'(0));
    check("reset_level", 64'(fifo_level),   64'(0));
    check("reset_ovf",   64'(overflow),     64'(0));
    check("reset_ferr",  64'(frame_error),  64'(0));
    reset = 1'b1;
    idle(2);
    enable = 1'b1;
    sample_ready = 1'b1;
    for (int s = 0; s < 32; s++) bit_slot(1'b1, 1'($urandom), 0, 1'b0, 32'h0, 1'b0);

    // basic frame with latency bound
    send_frame(16'hA5C3, 16'h5A3C, 1'b1, 32, -1, 0, 0, 1'b1);
    idle(10);
    check("t1_pop",   64'(last_pop),   64'(32'hA5C35A3C));
    check("t1_level", 64'(fifo_level), 64'(0));

    // enable arrives mid right word
    enable = 1'b0;
    idle(4);
    send_frame(16'h1111, 16'h2222, 1'b0, 32, 1, 8, 1);
    check("t2_level_partial", 64'(fifo_level), 64'(0));
    send_frame(16'hBEEF, 16'hCAFE, 1'b1);
    idle(10);
    check("t2_pop", 64'(last_pop), 64'(32'hBEEFCAFE));

    // overflow: nine frames into eight entries
    sample_ready = 1'b0;
    for (int i = 1; i <= 9; i++)
      send_frame(16'(16'h1000 + i), 16'(16'h2000 + 3 * i), 1'b1);
    idle(10);
    check("t3_level_full", 64'(fifo_level),  64'(8));
    check("t3_ovf",        64'(overflow),    64'(1));
    check("t3_ferr",       64'(frame_error), 64'(0));
    sample_ready = 1'b1;
    idle(20);
    check("t3_level_drain", 64'(fifo_level), 64'(0));
    check("t3_last_pop",    64'(last_pop),   64'(32'h10082018));
    check("t3_ovf_sticky",  64'(overflow),   64'(1));
    pulse_clear();
    check("t3_ovf_clear",   64'(overflow),   64'(0));

    // short left word
    send_frame(16'hF0F0, 16'h0F0F, 1'b0, 11);
    send_frame(16'h1357, 16'h2468, 1'b1);
    idle(10);
    check("t4_ferr",  64'(frame_error), 64'(1));
    check("t4_pop",   64'(last_pop),    64'(32'h13572468));
    check("t4_level", 64'(fifo_level),  64'(0));
    pulse_clear();
    check("t4_ferr_clear", 64'(frame_error), 64'(0));

    // disable during the right word with three frames queued
    sample_ready = 1'b0;
    for (int i = 1; i <= 3; i++)
      send_frame(16'(16'h3000 + i), 16'(16'h4000 + i), 1'b1);
    send_frame(16'h5555, 16'h6666, 1'b0, 32, 1, 5, 2);
    idle(10);
    check("t5_level", 64'(fifo_level), 64'(3));
    check("t5_flags", 64'({overflow, frame_error}), 64'(0));
    enable = 1'b1;
    sample_ready = 1'b1;
    idle(20);
    check("t5_level_drain", 64'(fifo_level), 64'(0));
    check("t5_last_pop",    64'(last_pop),   64'(32'h30034003));

    // reset mid frame, then resume
    sample_ready = 1'b0;
    send_frame(16'h7777, 16'h8888, 1'b1);
    idle(10);
    check("t6_level_pre", 64'(fifo_level), 64'(1));
    send_frame(16'h9999, 16'hAAAA, 1'b0, 32, 0, 8, 3);
    check("t6_level_post", 64'(fifo_level), 64'(0));
    sample_ready = 1'b1;
    send_frame(16'hC0DE, 16'hF00D, 1'b1);
    idle(10);
    check("t6_pop",   64'(last_pop),   64'(32'hC0DEF00D));
    check("t6_level", 64'(fifo_level), 64'(0));
    check("t6_model_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
